// File: rtl/apb_pkg.sv
// Shared types and constants for the two-requester APB master.
package apb_pkg;

    localparam int APB_ADDR_W      = 32;
    localparam int APB_DATA_W      = 32;
    localparam int APB_TIMEOUT_DEF = 16;
    localparam int APB_NUM_REQ     = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } apb_state_t;

    // Requester index to one-hot requester mask.
    function automatic logic [APB_NUM_REQ-1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/apb_rr_arb.sv
// Two-way round-robin arbiter. The pointer remembers the last winner so the
// other requester is preferred when both are asking.
module apb_rr_arb
    import apb_pkg::*;
(
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic [APB_NUM_REQ-1:0] req,
    input  logic                   take,
    output logic [APB_NUM_REQ-1:0] grant,
    output logic                   grant_idx
);

    logic last;

    // Pick a winner: a lone requester wins outright, a tie goes to the one not served last.
    always_comb begin
        grant_idx = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last;
            default: grant_idx = 1'b0;
        endcase
        grant = (|req) ? idx_to_onehot(grant_idx) : 2'b00;
    end

    // Last-grant pointer; resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            last <= 1'b1;
        end else if (take && (|req)) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters through a round-robin arbiter.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | bus quiet; grant a requester and latch its transfer
//   SETUP  | psel=1, penable=0, address/data/direction presented
//   ACCESS | psel=1, penable=1; wait for pready or the timeout
//   DONE   | bus quiet; rsp_valid pulses to the owning requester
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT = APB_TIMEOUT_DEF
) (
    input  logic                                    pclk,
    input  logic                                    presetn,
    input  logic [APB_NUM_REQ-1:0]                  req_valid,
    input  logic [APB_NUM_REQ-1:0]                  req_write,
    input  logic [APB_NUM_REQ-1:0][APB_ADDR_W-1:0]  req_addr,
    input  logic [APB_NUM_REQ-1:0][APB_DATA_W-1:0]  req_wdata,
    output logic [APB_NUM_REQ-1:0]                  req_ready,
    output logic [APB_NUM_REQ-1:0]                  rsp_valid,
    output logic [APB_DATA_W-1:0]                   rsp_rdata,
    output logic                                    rsp_err,
    output logic                                    psel,
    output logic                                    penable,
    output logic                                    pwrite,
    output logic [APB_ADDR_W-1:0]                   paddr,
    output logic [APB_DATA_W-1:0]                   pwdata,
    input  logic [APB_DATA_W-1:0]                   prdata,
    input  logic                                    pready,
    input  logic                                    pslverr
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_t state, state_nx;

    logic [APB_NUM_REQ-1:0] grant;
    logic                   grant_idx;
    logic                   take;
    logic                   owner;
    logic [CNT_W-1:0]       acc_cnt;
    logic                   timeout_hit;
    logic                   xfer_end;

    logic                   psel_nx;
    logic                   penable_nx;
    logic [APB_NUM_REQ-1:0] rsp_valid_nx;

    assign take        = (state == IDLE) && (|req_valid);
    assign timeout_hit = (acc_cnt == CNT_LAST);
    assign xfer_end    = (state == ACCESS) && (pready || timeout_hit);

    apb_rr_arb u_arb (
        .pclk      (pclk),
        .presetn   (presetn),
        .req       (req_valid),
        .take      (take),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // State register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req_valid) state_nx = SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (xfer_end) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode: combinational accept pulse, and next values for the registered bus/response outputs.
    always_comb begin
        req_ready    = 2'b00;
        psel_nx      = 1'b0;
        penable_nx   = 1'b0;
        rsp_valid_nx = 2'b00;
        // The accept pulse is gated by reset so nothing is accepted while presetn is low.
        if ((state == IDLE) && presetn) begin
            req_ready = grant;
        end
        if ((state_nx == SETUP) || (state_nx == ACCESS)) begin
            psel_nx = 1'b1;
        end
        if (state_nx == ACCESS) begin
            penable_nx = 1'b1;
        end
        if (state_nx == DONE) begin
            rsp_valid_nx = idx_to_onehot(owner);
        end
    end

    // Registered APB controls, transfer latch and response capture.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            owner     <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            psel      <= psel_nx;
            penable   <= penable_nx;
            rsp_valid <= rsp_valid_nx;
            // paddr/pwdata/pwrite double as the latch, so they stay put until the next grant.
            if (take) begin
                owner  <= grant_idx;
                pwrite <= req_write[grant_idx];
                paddr  <= req_addr[grant_idx];
                pwdata <= req_wdata[grant_idx];
            end
            if (xfer_end) begin
                if (pready) begin
                    rsp_rdata <= pwrite ? '0 : prdata;
                    rsp_err   <= pslverr;
                end else begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
        end
    end

    // ACCESS cycle counter: cleared on entry, saturates at the timeout compare value.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            acc_cnt <= '0;
        end else if ((state_nx == ACCESS) && (state != ACCESS)) begin
            acc_cnt <= '0;
        end else if ((state == ACCESS) && !timeout_hit) begin
            acc_cnt <= acc_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master with a small behavioural APB slave.
module tb_apb_arb_master;

    typedef struct {
        int          r;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wt;
        logic        err;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic              pclk = 1'b0;
    logic              presetn = 1'b0;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_write = 2'b00;
    logic [1:0][31:0]  req_addr = '0;
    logic [1:0][31:0]  req_wdata = '0;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              psel, penable, pwrite;
    logic [31:0]       paddr, pwdata;
    logic [31:0]       prdata = '0;
    logic              pready = 1'b0;
    logic              pslverr = 1'b0;

    int total = 0;
    int bad = 0;

    // Slave behaviour knobs and bookkeeping.
    int          cur_wait = 0;
    logic        cur_err = 1'b0;
    int          wcnt = 0;
    int          stab_err = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_write;
    logic [31:0] mem [0:63];

    vec_t vecs [8];

    apb_arb_master #(.TIMEOUT(16)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 pclk = ~pclk;

    // Behavioural slave: answers after cur_wait extra ACCESS cycles, checks bus stability.
    always @(negedge pclk) begin
        if (psel && penable) begin
            if (wcnt == 0) begin
                cap_addr  = paddr;
                cap_wdata = pwdata;
                cap_write = pwrite;
            end else if (paddr !== cap_addr || pwdata !== cap_wdata || pwrite !== cap_write) begin
                stab_err++;
            end
            if (wcnt == cur_wait) begin
                pready  = 1'b1;
                pslverr = cur_err;
                if (cur_err)
                    prdata = 32'h0;
                else if (pwrite)
                    prdata = 32'hBAD0_0000 | paddr;
                else
                    prdata = mem[paddr[5:0]];
                if (pwrite && !cur_err)
                    mem[paddr[5:0]] = pwdata;
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = 32'h0;
            end
            wcnt++;
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = 32'h0;
            wcnt    = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic expire(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic tick;
        @(negedge pclk);
        #1;
    endtask

    function automatic logic [1:0] oh(input int r);
        return (r == 0) ? 2'b01 : 2'b10;
    endfunction

    // One single-requester transfer, checked from grant through completion.
    task automatic xfer(input vec_t v, input string nm);
        int lat;
        int n;
        req_write[v.r] = v.we;
        req_addr[v.r]  = v.addr;
        req_wdata[v.r] = v.wdata;
        cur_wait = v.wt;
        cur_err  = v.err;
        stab_err = 0;
        req_valid[v.r] = 1'b1;
        #1;
        n = 0;
        while (req_ready[v.r] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            expire({nm, " grant"});
            req_valid = 2'b00;
            return;
        end
        chk({nm, " ready"}, 32'(req_ready), 32'(oh(v.r)));
        tick();
        req_valid[v.r] = 1'b0;
        chk({nm, " setup ctl"}, 32'({psel, penable}), 32'h2);
        chk({nm, " setup addr"}, paddr, v.addr);
        chk({nm, " setup dir"}, 32'(pwrite), 32'(v.we));
        chk({nm, " ready pulse"}, 32'(req_ready), 32'h0);
        if (v.we) chk({nm, " setup wdata"}, pwdata, v.wdata);
        lat = 1;
        while (rsp_valid == 2'b00 && lat < 60) begin
            tick();
            lat++;
            if (lat == 2) chk({nm, " access ctl"}, 32'({psel, penable}), 32'h3);
        end
        if (rsp_valid == 2'b00) begin
            expire({nm, " rsp"});
            return;
        end
        chk({nm, " rsp owner"}, 32'(rsp_valid), 32'(oh(v.r)));
        chk({nm, " rdata"}, rsp_rdata, v.exp_rdata);
        chk({nm, " err"}, 32'(rsp_err), 32'(v.exp_err));
        chk({nm, " latency"}, lat, v.exp_lat);
        tick();
        chk({nm, " rsp pulse"}, 32'(rsp_valid), 32'h0);
        chk({nm, " psel low"}, 32'(psel), 32'h0);
        chk({nm, " rdata hold"}, rsp_rdata, v.exp_rdata);
        chk({nm, " stable"}, stab_err, 0);
    endtask

    initial begin
        int n;
        int quiet;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[40] = 32'h4040_4040;

        //            r  we  addr   wdata          wt  err  rdata          err  lat
        vecs[0] = '{0, 1'b1, 32'd5,  32'hDEAD_BEEF, 0,  1'b0, 32'h0,         1'b0, 3};
        vecs[1] = '{0, 1'b0, 32'd5,  32'h0,         0,  1'b0, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[2] = '{1, 1'b1, 32'd12, 32'h1234_5678, 3,  1'b0, 32'h0,         1'b0, 6};
        vecs[3] = '{1, 1'b0, 32'd12, 32'h0,         3,  1'b0, 32'h1234_5678, 1'b0, 6};
        vecs[4] = '{0, 1'b0, 32'd40, 32'h0,         0,  1'b1, 32'h0,         1'b1, 3};
        vecs[5] = '{1, 1'b0, 32'd40, 32'h0,         99, 1'b0, 32'h0,         1'b1, 18};
        vecs[6] = '{0, 1'b1, 32'd40, 32'hCAFE_F00D, 1,  1'b0, 32'h0,         1'b0, 4};
        vecs[7] = '{1, 1'b0, 32'd40, 32'h0,         0,  1'b0, 32'hCAFE_F00D, 1'b0, 3};

        // Reset state, with requests present to show nothing is accepted.
        req_valid = 2'b11;
        tick();
        tick();
        chk("rst req_ready", 32'(req_ready), 32'h0);
        chk("rst ctl", 32'({psel, penable, pwrite}), 32'h0);
        chk("rst paddr", paddr, 32'h0);
        chk("rst pwdata", pwdata, 32'h0);
        chk("rst rsp", 32'({rsp_valid, rsp_err}), 32'h0);
        chk("rst rdata", rsp_rdata, 32'h0);
        req_valid = 2'b00;
        presetn = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) xfer(vecs[i], $sformatf("vec%0d", i));

        // Both requesters held valid: grants alternate 0,1,0,1.
        req_write = 2'b00;
        req_addr[0] = 32'd5;
        req_addr[1] = 32'd12;
        cur_wait = 0;
        cur_err  = 1'b0;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            int e;
            e = k % 2;
            n = 0;
            while (req_ready == 2'b00 && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) begin
                expire($sformatf("rr%0d grant", k));
                break;
            end
            chk($sformatf("rr%0d grant", k), 32'(req_ready), 32'(oh(e)));
            tick();
            req_valid[e] = 1'b0;
            n = 0;
            while (rsp_valid == 2'b00 && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) begin
                expire($sformatf("rr%0d rsp", k));
                break;
            end
            chk($sformatf("rr%0d owner", k), 32'(rsp_valid), 32'(oh(e)));
            chk($sformatf("rr%0d rdata", k), rsp_rdata, (e == 0) ? 32'hDEAD_BEEF : 32'h1234_5678);
            if (k < 3) req_valid[e] = 1'b1;
            else req_valid = 2'b00;
        end
        tick();

        // Reset during ACCESS: transfer abandoned, pointer back to requester 0.
        req_write[0] = 1'b0;
        req_addr[0]  = 32'd7;
        cur_wait = 99;
        req_valid[0] = 1'b1;
        #1;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) expire("rstacc grant");
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        chk("rstacc in access", 32'({psel, penable}), 32'h3);
        presetn = 1'b0;
        #1;
        chk("rstacc ctl", 32'({psel, penable, pwrite}), 32'h0);
        chk("rstacc paddr", paddr, 32'h0);
        chk("rstacc rsp", 32'({rsp_valid, rsp_err, req_ready}), 32'h0);
        chk("rstacc rdata", rsp_rdata, 32'h0);
        tick();
        presetn = 1'b1;
        quiet = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid != 2'b00 || psel) quiet++;
        end
        chk("rstacc quiet", quiet, 0);
        cur_wait = 0;
        req_addr[1] = 32'd12;
        req_valid = 2'b11;
        #1;
        chk("rstacc regrant", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        n = 0;
        while (rsp_valid == 2'b00 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) expire("rstacc rsp");
        else chk("rstacc owner", 32'(rsp_valid), 32'h1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of ACCESS cycles allowed without pready.
REQ-002 Port pclk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-003 Port presetn  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port req_valid  in  2  SHALL carry the per-requester transfer request, held until accepted.
REQ-005 Port req_write  in  2  SHALL select the per-requester direction: 1 = write, 0 = read.
REQ-006 Port req_addr  in  2x32  SHALL carry the per-requester address.
REQ-007 Port req_wdata  in  2x32  SHALL carry the per-requester write data.
REQ-008 Port req_ready  out  2  SHALL be a one-cycle accept pulse to the granted requester.
REQ-009 Port rsp_valid  out  2  SHALL be a one-cycle completion pulse to the owning requester.
REQ-010 Port rsp_rdata  out  32  SHALL return read data, valid with rsp_valid.
REQ-011 Port rsp_err  out  1  SHALL flag an error (pslverr or timeout), valid with rsp_valid.
REQ-012 Ports psel, penable, pwrite (out, 1 each) SHALL be the APB master controls.
REQ-013 Ports paddr, pwdata (out, 32 each) SHALL be the APB master address and write data.
REQ-014 Ports prdata (in, 32), pready (in, 1) and pslverr (in, 1) SHALL be the APB slave response.

Function
REQ-015 The FSM SHALL have states IDLE, SETUP, ACCESS, DONE.
- IDLE -> SETUP on any req_valid.
- SETUP -> ACCESS unconditionally.
- ACCESS -> DONE on pready or timeout.
- DONE -> IDLE.
REQ-016 In IDLE with any req_valid, the block SHALL grant round-robin.
- The requester not granted last wins when both are valid.
- The grant SHALL drive req_ready[g]=1 combinationally for that cycle only.
- The grant SHALL latch write, addr and wdata.
REQ-017 APB outputs SHALL be registered.
- SETUP: psel=1, penable=0, with paddr/pwrite/pwdata from the latch.
- ACCESS: psel=1, penable=1.
- IDLE/DONE: psel=0, penable=0.
REQ-018 paddr, pwdata and pwrite SHALL stay stable from SETUP through the final ACCESS cycle.
REQ-019 In ACCESS, on pready=1 the block SHALL capture:
- rsp_rdata = read ? prdata : 0;
- rsp_err = pslverr.
REQ-020 A cycle counter SHALL clear on entering ACCESS.
- If TIMEOUT ACCESS cycles elapse without pready, the transfer ends with rsp_err=1 and rsp_rdata=0.
REQ-021 In DONE, the block SHALL set rsp_valid[g]=1 for exactly one cycle; rsp_rdata and rsp_err hold until the next completion.
REQ-022 Back-to-back transfers SHALL have psel low for at least two cycles (DONE + IDLE); minimum transfer latency is req_ready to rsp_valid = 3 cycles.
REQ-023 A req_valid that deasserts before its grant SHALL be dropped silently; requests arriving during a transfer wait in IDLE.
REQ-024 With both requesters valid continuously, grants SHALL alternate 0,1,0,1,...

Reset
REQ-025 Asserting presetn low SHALL immediately force state=IDLE and zero every output (psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata, rsp_err).
REQ-026 Reset SHALL clear the timeout counter and set the last-grant pointer to 1, so requester 0 wins first.
REQ-027 A transfer interrupted by reset SHALL be abandoned with no rsp_valid; operation SHALL resume on the first clock edge after presetn deasserts.

Structure
REQ-028 Shared package apb_pkg SHALL hold:
- the state enum (IDLE, SETUP, ACCESS, DONE);
- APB_ADDR_W=32 and APB_DATA_W=32;
- the default TIMEOUT.
REQ-029 A sub-module apb_rr_arb SHALL implement the 2-way round-robin grant and last-grant pointer; the FSM, latch and counter stay in apb_arb_master.

Verification
REQ-030 Write then read from req0, slave with zero wait states: write 0xDEADBEEF to addr 5, then read addr 5 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid[0] once per transfer.
REQ-031 Both requesters valid for 4 transfers -> grant order 0,1,0,1; each rsp_valid pulses only on the owner's bit.
REQ-032 Read addr 40 with the slave returning pslverr=1 -> rsp_err=1 and rsp_rdata=0.
REQ-033 Slave holds pready=0 and TIMEOUT=16 -> rsp_valid 16 ACCESS cycles after penable rises, rsp_err=1, psel drops.
REQ-034 Slave with 3 wait states: paddr/pwdata stable across all ACCESS cycles; completion on the cycle pready=1.
REQ-035 presetn pulsed low during ACCESS -> psel=0 immediately, no rsp_valid; the next request is granted to requester 0.
